// File: rtl/led_show_ctrl.sv
// LED pattern show controller.
// A debounced pushbutton cycles through four LED patterns (SCAN, FILL,
// BLINK, CHASE). Patterns advance one step every STEP_DIV clock cycles
// unless frozen by hold.
//
// Ports:
//   clki      - system clock, all state changes on the rising edge
//   reset     - asynchronous, active-low reset
//   btn       - raw asynchronous mode-advance pushbutton (active high)
//   hold      - synchronous freeze of pattern stepping (active high)
//   leds      - registered LED pattern, bit0 = LED0
//   mode      - registered current mode: 0 SCAN, 1 FILL, 2 BLINK, 3 CHASE
//   step_tick - registered one-cycle pulse in the cycle after each step
module led_show_ctrl #(
    parameter int unsigned STEP_DIV     = 4_000_000,
    parameter int unsigned DEBOUNCE_CYC = 240_000
) (
    input  logic       clki,
    input  logic       reset,
    input  logic       btn,
    input  logic       hold,
    output logic [7:0] leds,
    output logic [1:0] mode,
    output logic       step_tick
);

    localparam int unsigned PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int unsigned DW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(STEP_DIV - 1);
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYC - 1);

    typedef enum logic [1:0] {
        ModeScan  = 2'd0,
        ModeFill  = 2'd1,
        ModeBlink = 2'd2,
        ModeChase = 2'd3
    } mode_e;

    logic          sync1_q, sync2_q;
    logic          db_level_q;
    logic [DW-1:0] deb_cnt_q;
    logic [PW-1:0] presc_q;
    mode_e         mode_q;
    logic [7:0]    leds_q;
    logic          tick_q;
    logic [2:0]    pos_q;
    logic          dir_up_q;
    logic [3:0]    fill_cnt_q;

    logic          deb_done;
    logic          adv;
    logic          step;
    mode_e         mode_next;
    logic [7:0]    start_leds;
    logic [7:0]    step_leds;
    logic [2:0]    pos_d;
    logic          dir_up_d;
    logic [3:0]    fill_cnt_d;

    always_comb begin
        // Debounce accepts the synchronized level after DEBOUNCE_CYC
        // consecutive differing cycles; only a rising acceptance advances.
        deb_done  = (sync2_q != db_level_q) && (deb_cnt_q == DEB_LAST);
        adv       = deb_done && sync2_q;
        step      = !hold && (presc_q == PRESC_LAST);
        mode_next = mode_e'(mode_q + 2'd1);

        start_leds = 8'h01;
        case (mode_next)
            ModeScan:  start_leds = 8'h01;
            ModeFill:  start_leds = 8'h00;
            ModeBlink: start_leds = 8'hFF;
            ModeChase: start_leds = 8'h01;
            default:   start_leds = 8'h01;
        endcase

        pos_d      = pos_q;
        dir_up_d   = dir_up_q;
        fill_cnt_d = fill_cnt_q;
        step_leds  = leds_q;
        case (mode_q)
            ModeScan: begin
                // Bounce: turning around at an endpoint moves straight to
                // its neighbour so each endpoint is shown for one step.
                if (dir_up_q) begin
                    if (pos_q == 3'd7) begin
                        pos_d    = 3'd6;
                        dir_up_d = 1'b0;
                    end else begin
                        pos_d = pos_q + 3'd1;
                    end
                end else begin
                    if (pos_q == 3'd0) begin
                        pos_d    = 3'd1;
                        dir_up_d = 1'b1;
                    end else begin
                        pos_d = pos_q - 3'd1;
                    end
                end
                step_leds = 8'd1 << pos_d;
            end
            ModeFill: begin
                fill_cnt_d = (fill_cnt_q == 4'd8) ? 4'd0 : fill_cnt_q + 4'd1;
                step_leds  = 8'((9'd1 << fill_cnt_d) - 9'd1);
            end
            ModeBlink: step_leds = ~leds_q;
            ModeChase: step_leds = {leds_q[6:0], leds_q[7]};
            default:   step_leds = leds_q;
        endcase
    end

    always_ff @(posedge clki or negedge reset) begin
        if (!reset) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            db_level_q <= 1'b0;
            deb_cnt_q  <= '0;
            presc_q    <= '0;
            mode_q     <= ModeScan;
            leds_q     <= 8'h01;
            tick_q     <= 1'b0;
            pos_q      <= 3'd0;
            dir_up_q   <= 1'b1;
            fill_cnt_q <= 4'd0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;

            if (sync2_q == db_level_q) begin
                deb_cnt_q <= '0;
            end else if (deb_done) begin
                db_level_q <= sync2_q;
                deb_cnt_q  <= '0;
            end else begin
                deb_cnt_q <= deb_cnt_q + DW'(1);
            end

            // A coincident mode advance suppresses the step and its tick.
            tick_q <= step && !adv;

            if (adv) begin
                mode_q     <= mode_next;
                presc_q    <= '0;
                leds_q     <= start_leds;
                pos_q      <= 3'd0;
                dir_up_q   <= 1'b1;
                fill_cnt_q <= 4'd0;
            end else if (!hold) begin
                if (step) begin
                    presc_q    <= '0;
                    leds_q     <= step_leds;
                    pos_q      <= pos_d;
                    dir_up_q   <= dir_up_d;
                    fill_cnt_q <= fill_cnt_d;
                end else begin
                    presc_q <= presc_q + PW'(1);
                end
            end
        end
    end

    assign leds      = leds_q;
    assign mode      = mode_q;
    assign step_tick = tick_q;

endmodule

// File: tb/tb_led_show_ctrl.sv
module tb_led_show_ctrl;

    localparam int unsigned StepDiv = 4;
    localparam int unsigned DebCyc  = 8;

    logic       clki = 1'b0;
    logic       reset = 1'b0;
    logic       btn = 1'b0;
    logic       hold = 1'b0;
    logic [7:0] leds;
    logic [1:0] mode;
    logic       step_tick;

    int tests_run = 0;
    int tests_failed = 0;

    // Scoreboard of expected LED values, one per step.
    logic [7:0] exp_q[$];

    led_show_ctrl #(
        .STEP_DIV     (StepDiv),
        .DEBOUNCE_CYC (DebCyc)
    ) dut (
        .clki      (clki),
        .reset     (reset),
        .btn       (btn),
        .hold      (hold),
        .leds      (leds),
        .mode      (mode),
        .step_tick (step_tick)
    );

    always #5 clki = ~clki;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Waits for the next step_tick (sampled at negedge); -1 on timeout.
    task automatic wait_tick(input int budget, output int cycles);
        cycles = 0;
        do begin
            @(negedge clki);
            cycles++;
        end while (step_tick !== 1'b1 && cycles < budget);
        if (step_tick !== 1'b1) cycles = -1;
    endtask

    // Raises btn until mode changes (bounded), then releases it.
    task automatic press(output int cycles);
        logic [1:0] m0;
        m0 = mode;
        btn = 1'b1;
        cycles = 0;
        do begin
            @(negedge clki);
            cycles++;
        end while (mode === m0 && cycles < 40);
        btn = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clki);
        tests_run++;
        if (leds !== 8'h01) begin
            tests_failed++;
            $display("FAIL reset_leds: got %h want 01", leds);
        end
        tests_run++;
        if (mode !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset_mode: got %0d want 0", mode);
        end
        tests_run++;
        if (step_tick !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_tick: got %b want 0", step_tick);
        end
    endtask

    task automatic test_scan();
        int cyc;
        logic [7:0] exp;
        logic [7:0] tbl [16] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                                 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02, 8'h04};
        foreach (tbl[i]) exp_q.push_back(tbl[i]);
        reset = 1'b1;
        while (exp_q.size() > 0) begin
            wait_tick(StepDiv + 4, cyc);
            exp = exp_q.pop_front();
            tests_run++;
            if (cyc !== StepDiv || leds !== exp) begin
                tests_failed++;
                $display("FAIL scan_step: leds=%h cycles=%0d, want leds=%h cycles=%0d",
                         leds, cyc, exp, StepDiv);
            end
        end
        tests_run++;
        if (mode !== 2'd0) begin
            tests_failed++;
            $display("FAIL scan_mode: got %0d want 0", mode);
        end
    endtask

    task automatic test_fill();
        int cyc;
        logic [7:0] exp;
        logic [7:0] tbl [10] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
                                 8'h00, 8'h01};
        press(cyc);
        tests_run++;
        if (cyc !== 2 + DebCyc || mode !== 2'd1 || leds !== 8'h00 || step_tick !== 1'b0) begin
            tests_failed++;
            $display("FAIL fill_enter: cycles=%0d mode=%0d leds=%h tick=%b, want 10 1 00 0",
                     cyc, mode, leds, step_tick);
        end
        foreach (tbl[i]) exp_q.push_back(tbl[i]);
        while (exp_q.size() > 0) begin
            wait_tick(StepDiv + 4, cyc);
            exp = exp_q.pop_front();
            tests_run++;
            if (cyc !== StepDiv || leds !== exp) begin
                tests_failed++;
                $display("FAIL fill_step: leds=%h cycles=%0d, want leds=%h cycles=%0d",
                         leds, cyc, exp, StepDiv);
            end
        end
    endtask

    task automatic test_glitch();
        btn = 1'b1;
        repeat (5) @(negedge clki);
        btn = 1'b0;
        repeat (20) @(negedge clki);
        tests_run++;
        if (mode !== 2'd1) begin
            tests_failed++;
            $display("FAIL glitch_mode: got %0d want 1", mode);
        end
    endtask

    task automatic test_modes();
        int cyc;
        logic [7:0] exp;
        logic [1:0] want_mode [3] = '{2'd2, 2'd3, 2'd0};
        logic [7:0] want_start [3] = '{8'hFF, 8'h01, 8'h01};
        for (int m = 0; m < 3; m++) begin
            press(cyc);
            tests_run++;
            if (mode !== want_mode[m] || leds !== want_start[m] || step_tick !== 1'b0) begin
                tests_failed++;
                $display("FAIL mode_enter: mode=%0d leds=%h tick=%b, want %0d %h 0",
                         mode, leds, step_tick, want_mode[m], want_start[m]);
            end
            case (m)
                0: begin
                    exp_q.push_back(8'h00); exp_q.push_back(8'hFF);
                    exp_q.push_back(8'h00); exp_q.push_back(8'hFF);
                end
                1: begin
                    for (int b = 1; b < 8; b++) exp_q.push_back(8'h01 << b);
                    exp_q.push_back(8'h01);
                end
                default: begin
                    exp_q.push_back(8'h02); exp_q.push_back(8'h04);
                end
            endcase
            while (exp_q.size() > 0) begin
                wait_tick(StepDiv + 4, cyc);
                exp = exp_q.pop_front();
                tests_run++;
                if (cyc !== StepDiv || leds !== exp) begin
                    tests_failed++;
                    $display("FAIL mode%0d_step: leds=%h cycles=%0d, want leds=%h cycles=%0d",
                             want_mode[m], leds, cyc, exp, StepDiv);
                end
            end
        end
    endtask

    task automatic test_hold();
        int cyc;
        int bad;
        // Two edges after a step the prescaler holds 2.
        repeat (2) @(negedge clki);
        hold = 1'b1;
        bad = 0;
        repeat (20) begin
            @(negedge clki);
            if (step_tick !== 1'b0 || leds !== 8'h04) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL hold_frozen: %0d bad cycles, want 0", bad);
        end
        hold = 1'b0;
        wait_tick(StepDiv + 4, cyc);
        tests_run++;
        if (cyc !== 2 || leds !== 8'h08) begin
            tests_failed++;
            $display("FAIL hold_resume: cycles=%0d leds=%h, want 2 08", cyc, leds);
        end
    endtask

    task automatic test_collide();
        int cyc;
        // Press lands its acceptance on the 12th edge after a step: a step edge.
        repeat (2) @(negedge clki);
        press(cyc);
        tests_run++;
        if (cyc !== 2 + DebCyc || mode !== 2'd1 || leds !== 8'h00 || step_tick !== 1'b0) begin
            tests_failed++;
            $display("FAIL collide: cycles=%0d mode=%0d leds=%h tick=%b, want 10 1 00 0",
                     cyc, mode, leds, step_tick);
        end
        wait_tick(StepDiv + 4, cyc);
        tests_run++;
        if (cyc !== StepDiv || leds !== 8'h01) begin
            tests_failed++;
            $display("FAIL collide_next: cycles=%0d leds=%h, want 4 01", cyc, leds);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        int total;
        wait_tick(StepDiv + 4, cyc);
        #2;
        reset = 1'b0;
        btn = 1'b1;
        #1;
        tests_run++;
        if (leds !== 8'h01 || mode !== 2'd0 || step_tick !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_async: leds=%h mode=%0d tick=%b, want 01 0 0",
                     leds, mode, step_tick);
        end
        @(negedge clki);
        reset = 1'b1;
        wait_tick(StepDiv + 4, cyc);
        tests_run++;
        if (cyc !== StepDiv || leds !== 8'h02 || mode !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset_first_step: cycles=%0d leds=%h mode=%0d, want 4 02 0",
                     cyc, leds, mode);
        end
        total = (cyc > 0) ? cyc : 0;
        while (mode === 2'd0 && total < 40) begin
            @(negedge clki);
            total++;
        end
        btn = 1'b0;
        tests_run++;
        if (total !== 2 + DebCyc || mode !== 2'd1 || leds !== 8'h00) begin
            tests_failed++;
            $display("FAIL btn_through_reset: cycles=%0d mode=%0d leds=%h, want 10 1 00",
                     total, mode, leds);
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_fill();
        test_glitch();
        test_modes();
        test_hold();
        test_collide();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
